// File: rtl/mp_regfile_pkg.sv
// rtl/mp_regfile_pkg.sv - shared types and write-conflict helper for mp_regfile_nrnw
package mp_regfile_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} mp_state_e;

  // Upper bounds the helper is sized for; callers zero-extend narrower buses.
  localparam int MAX_WR = 8;
  localparam int MAX_AW = 16;

  // A port survives only if no higher-index enabled port targets the same address.
  function automatic logic [MAX_WR-1:0] wr_winner_mask(
    input logic [MAX_WR-1:0][MAX_AW-1:0] wa,
    input logic [MAX_WR-1:0]             we
  );
    logic [MAX_WR-1:0] mask;
    mask = we;
    for (int i = 0; i < MAX_WR; i++) begin
      for (int j = i + 1; j < MAX_WR; j++) begin
        if (we[j] && (wa[j] == wa[i])) mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/mp_wr_arbiter.sv
// rtl/mp_wr_arbiter.sv - range check and highest-port-wins masking of write enables
module mp_wr_arbiter
  import mp_regfile_pkg::*;
#(
  parameter int WrNum = 2,
  parameter int Depth = 32
) (
  input  logic [WrNum-1:0][$clog2(Depth)-1:0] i_wa,
  input  logic [WrNum-1:0]                    i_we,
  output logic [WrNum-1:0]                    o_we_q
);

  localparam int AW = $clog2(Depth);

  logic [MAX_WR-1:0][MAX_AW-1:0] w_wa_ext;
  logic [MAX_WR-1:0]             w_we_ext;
  logic [MAX_WR-1:0]             w_mask;
  logic                          w_unused_mask;

  // Drop out-of-range writes first so they can never mask an in-range port.
  always_comb begin
    w_wa_ext = '0;
    w_we_ext = '0;
    for (int i = 0; i < WrNum; i++) begin
      w_wa_ext[i][AW-1:0] = i_wa[i];
      w_we_ext[i]         = i_we[i] && (int'(i_wa[i]) < Depth);
    end
  end

  assign w_mask        = wr_winner_mask(w_wa_ext, w_we_ext);
  assign o_we_q        = w_mask[WrNum-1:0];
  assign w_unused_mask = ^w_mask;

endmodule

// File: rtl/mp_regfile_nrnw.sv
// rtl/mp_regfile_nrnw.sv - LVT multi-read multi-write register file with reset sweep and bypass
module mp_regfile_nrnw
  import mp_regfile_pkg::*;
#(
  parameter int               Width     = 32,
  parameter int               Depth     = 32,
  parameter int               RdNum     = 4,
  parameter int               WrNum     = 2,
  parameter int               RdLatency = 0,
  parameter int               Bypass    = 1,
  parameter logic [Width-1:0] ResetVal  = '0
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_clear,
  input  logic [WrNum-1:0][$clog2(Depth)-1:0] i_wa,
  input  logic [WrNum-1:0]                    i_we,
  input  logic [WrNum-1:0][Width-1:0]         i_din,
  input  logic [RdNum-1:0][$clog2(Depth)-1:0] i_ra,
  output logic [RdNum-1:0][Width-1:0]         o_dout,
  output logic                                o_ready
);

  localparam int            AW       = $clog2(Depth);
  localparam int            LW       = (WrNum > 1) ? $clog2(WrNum) : 1;
  localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

  mp_state_e                   r_state;
  logic [AW-1:0]               r_init_addr;
  logic                        r_ready;
  logic [WrNum-1:0]            w_we_q;
  logic [WrNum-1:0]            w_wr_en;
  logic [WrNum-1:0][AW-1:0]    w_wr_addr;
  logic [WrNum-1:0][Width-1:0] w_wr_data;
  logic [Width-1:0]            r_bank [WrNum][RdNum][Depth];
  logic [LW-1:0]               r_lvt  [Depth];
  logic [RdNum-1:0][Width-1:0] w_rd_val;

  mp_wr_arbiter #(
    .WrNum (WrNum),
    .Depth (Depth)
  ) u_arb (
    .i_wa   (i_wa),
    .i_we   (i_we),
    .o_we_q (w_we_q)
  );

  // Sweep sequencer: INIT walks every address once, RUN accepts user writes until clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= INIT;
      r_init_addr <= '0;
      r_ready     <= 1'b0;
    end else if (i_clear) begin
      r_state     <= INIT;
      r_init_addr <= '0;
      r_ready     <= 1'b0;
    end else if (r_state == INIT) begin
      if (r_init_addr == LastAddr) begin
        r_state     <= RUN;
        r_init_addr <= '0;
        r_ready     <= 1'b1;
      end else begin
        r_init_addr <= r_init_addr + 1'b1;
      end
    end
  end

  // The sweep takes over port 0 during INIT; a clear in RUN drops that cycle's writes.
  always_comb begin
    w_wr_en   = '0;
    w_wr_addr = i_wa;
    w_wr_data = i_din;
    if (r_state == INIT) begin
      w_wr_en[0]   = 1'b1;
      w_wr_addr[0] = r_init_addr;
      w_wr_data[0] = ResetVal;
    end else if (!i_clear) begin
      w_wr_en = w_we_q;
    end
  end

  // Each read port owns a copy of every write port's bank; the LVT names the live copy.
  always_ff @(posedge i_clk) begin
    for (int w = 0; w < WrNum; w++) begin
      if (w_wr_en[w]) begin
        for (int r = 0; r < RdNum; r++) begin
          r_bank[w][r][w_wr_addr[w]] <= w_wr_data[w];
        end
        r_lvt[w_wr_addr[w]] <= LW'(w);
      end
    end
  end

  // Read priority: not ready or out of range gives ResetVal, then same-cycle bypass, then storage.
  always_comb begin
    w_rd_val = '0;
    for (int r = 0; r < RdNum; r++) begin
      w_rd_val[r] = r_bank[r_lvt[i_ra[r]]][r][i_ra[r]];
      if (Bypass != 0) begin
        for (int w = 0; w < WrNum; w++) begin
          if (w_wr_en[w] && (w_wr_addr[w] == i_ra[r])) w_rd_val[r] = w_wr_data[w];
        end
      end
      if (!r_ready || (int'(i_ra[r]) >= Depth)) w_rd_val[r] = ResetVal;
    end
  end

  generate
    if (RdLatency != 0) begin : g_reg_rd
      logic [RdNum-1:0][Width-1:0] r_dout;
      // Registered read ports capture this cycle's read value, bypass included.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_dout <= {RdNum{ResetVal}};
        else       r_dout <= w_rd_val;
      end
      assign o_dout = r_dout;
    end else begin : g_comb_rd
      assign o_dout = w_rd_val;
    end
  endgenerate

  assign o_ready = r_ready;

endmodule

// File: tb/tb_mp_regfile_nrnw.sv
// tb/tb_mp_regfile_nrnw.sv - self-checking bench for mp_regfile_nrnw over three configurations
module tb_mp_regfile_nrnw;

  localparam int NI = 3;
  // Instance 0: defaults; 1: Depth 20, read-old, nonzero reset; 2: registered, write-first.
  localparam int          DEP [NI] = '{32, 20, 32};
  localparam bit          BYP [NI] = '{1'b1, 1'b0, 1'b1};
  localparam bit          LAT [NI] = '{1'b0, 1'b0, 1'b1};
  localparam logic [31:0] RVL [NI] = '{32'h0, 32'h5A5A5A5A, 32'h0000C1C1};

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic [1:0]            we;
  logic [1:0][4:0]       wa;
  logic [1:0][31:0]      din;
  logic [3:0][4:0]       ra;
  logic [3:0][31:0]      dout [NI];
  logic                  rdy  [NI];

  int n_vec;
  int n_err;

  // Reference model: plain array contents, a ready flag and a sweep length counter.
  logic [31:0] mem [NI][32];
  bit          m_rdy [NI];
  int          m_cnt [NI];
  logic [31:0] m_q   [NI][4];

  typedef struct packed {
    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][31:0] din;
    logic [3:0][4:0]  ra;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  mp_regfile_nrnw #(.Width(32), .Depth(32), .RdNum(4), .WrNum(2), .RdLatency(0), .Bypass(1),
                    .ResetVal(32'h0)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_wa(wa), .i_we(we), .i_din(din), .i_ra(ra),
    .o_dout(dout[0]), .o_ready(rdy[0]));

  mp_regfile_nrnw #(.Width(32), .Depth(20), .RdNum(4), .WrNum(2), .RdLatency(0), .Bypass(0),
                    .ResetVal(32'h5A5A5A5A)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_wa(wa), .i_we(we), .i_din(din), .i_ra(ra),
    .o_dout(dout[1]), .o_ready(rdy[1]));

  mp_regfile_nrnw #(.Width(32), .Depth(32), .RdNum(4), .WrNum(2), .RdLatency(1), .Bypass(1),
                    .ResetVal(32'h0000C1C1)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_wa(wa), .i_we(we), .i_din(din), .i_ra(ra),
    .o_dout(dout[2]), .o_ready(rdy[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] r3,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.we = w;
    v.wa[0] = a0; v.din[0] = d0;
    v.wa[1] = a1; v.din[1] = d1;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  // Value a read port should see this cycle, from the current inputs and model state.
  function automatic logic [31:0] mread(input int k, input int r);
    logic [31:0] v;
    int a;
    a = int'(ra[r]);
    if (!m_rdy[k] || a >= DEP[k]) return RVL[k];
    v = mem[k][a];
    if (BYP[k] && !clear) begin
      for (int p = 0; p < 2; p++) begin
        if (we[p] && int'(wa[p]) == a) v = din[p];
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_rdy[k] = 1'b0;
      m_cnt[k] = 0;
      for (int a = 0; a < 32; a++) mem[k][a] = RVL[k];
      for (int r = 0; r < 4; r++) m_q[k][r] = RVL[k];
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      for (int r = 0; r < 4; r++) m_q[k][r] = mread(k, r);
      if (!m_rdy[k]) begin
        if (clear) m_cnt[k] = 0;
        else begin
          m_cnt[k]++;
          if (m_cnt[k] == DEP[k]) m_rdy[k] = 1'b1;
        end
      end else if (clear) begin
        m_rdy[k] = 1'b0;
        m_cnt[k] = 0;
        for (int a = 0; a < 32; a++) mem[k][a] = RVL[k];
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (we[p] && int'(wa[p]) < DEP[k]) mem[k][wa[p]] = din[p];
        end
      end
    end
  endtask

  task automatic step_pre();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("ready_i%0d", k), 32'(rdy[k]), 32'(m_rdy[k]));
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("dout_i%0d_p%0d", k, r), dout[k][r], LAT[k] ? m_q[k][r] : mread(k, r));
      end
    end
  endtask

  task automatic step_post();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0]  = mk(2'b11, 5'd3, 32'hFACEB00C, 5'd4, 32'hDEADBEEF, 5'd3, 5'd4, 5'd0, 5'd1,
                 32'hFACEB00C, 32'hDEADBEEF, 32'h0, 32'h0);
    tbl[1]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd3, 5'd4,
                 32'hFACEB00C, 32'hDEADBEEF, 32'hFACEB00C, 32'hDEADBEEF);
    tbl[2]  = mk(2'b11, 5'd4, 32'h44444444, 5'd3, 32'h33330000, 5'd0, 5'd1, 5'd2, 5'd5,
                 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd3, 5'd4,
                 32'h33330000, 32'h44444444, 32'h33330000, 32'h44444444);
    tbl[4]  = mk(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 5'd7, 5'd7, 5'd6, 5'd8,
                 32'h22222222, 32'h22222222, 32'h0, 32'h0);
    tbl[5]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 5'd7,
                 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
    tbl[6]  = mk(2'b01, 5'd7, 32'h33333333, 5'd7, 32'hDDDDDDDD, 5'd7, 5'd0, 5'd0, 5'd0,
                 32'h33333333, 32'h0, 32'h0, 32'h0);
    tbl[7]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 5'd7,
                 32'h33333333, 32'h33333333, 32'h33333333, 32'h33333333);
    tbl[8]  = mk(2'b01, 5'd3, 32'hC0FFEE00, 5'd0, 32'h0, 5'd3, 5'd3, 5'd4, 5'd7,
                 32'hC0FFEE00, 32'hC0FFEE00, 32'h44444444, 32'h33333333);
    tbl[9]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd7, 5'd0,
                 32'hC0FFEE00, 32'h44444444, 32'h33333333, 32'h0);
    tbl[10] = mk(2'b10, 5'd0, 32'h0, 5'd25, 32'hBAD0BAD0, 5'd25, 5'd3, 5'd9, 5'd10,
                 32'hBAD0BAD0, 32'hC0FFEE00, 32'h0, 32'h0);
    tbl[11] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd25, 5'd25, 5'd0, 5'd31,
                 32'hBAD0BAD0, 32'hBAD0BAD0, 32'h0, 32'h0);

    rst = 1'b1; clear = 1'b0; we = '0; wa = '0; din = '0; ra = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset sweep: ready timing per depth, with a write attempt that must be ignored.
    for (int e = 1; e <= 32; e++) begin
      we = (e <= 15) ? 2'b01 : 2'b00;
      wa[0] = 5'd3; din[0] = 32'hFACEB00C;
      ra = {5'd3, 5'd2, 5'd1, 5'd0};
      step();
      chk($sformatf("sweep_ready_a_e%0d", e), 32'(rdy[0]), 32'(e >= 32));
      chk($sformatf("sweep_ready_b_e%0d", e), 32'(rdy[1]), 32'(e >= 20));
    end
    we = '0;
    for (int i = 0; i < 8; i++) begin
      ra = {5'(4*i+3), 5'(4*i+2), 5'(4*i+1), 5'(4*i)};
      step();
    end
    ra = {5'd3, 5'd3, 5'd3, 5'd3};
    #1;
    chk("init_write_lost_a", dout[0][0], 32'h0);
    chk("init_write_lost_b", dout[1][0], 32'h5A5A5A5A);

    // Directed table: parallel writes, swapped ports, conflict, bypass, out-of-range.
    for (int i = 0; i < 12; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; din = tbl[i].din; ra = tbl[i].ra;
      step_pre();
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("tbl%0d_a_dout%0d", i, r), dout[0][r], tbl[i].exp[r]);
      end
      if (i == 8)  chk("read_old_b_same_cycle", dout[1][0], 32'h33330000);
      if (i == 9)  chk("lat1_c_bypass_next", dout[2][0], 32'hC0FFEE00);
      if (i == 11) chk("oor_read_b", dout[1][0], 32'h5A5A5A5A);
      step_post();
    end

    // Clear mid-run together with a write.
    we = 2'b11; wa = {5'd11, 5'd10}; din = {32'h0B0B0B0B, 32'h0A0A0A0A};
    step();
    wa = {5'd13, 5'd12}; din = {32'h0D0D0D0D, 32'h0C0C0C0C};
    step();
    clear = 1'b1; wa = {5'd15, 5'd14}; din = {32'hFEEDFACE, 32'hBEEFCAFE};
    ra = {5'd11, 5'd10, 5'd15, 5'd14};
    step();
    clear = 1'b0; we = '0;
    for (int k = 0; k < NI; k++) chk($sformatf("clear_drops_ready_i%0d", k), 32'(rdy[k]), 32'h0);
    for (int e = 1; e <= 32; e++) begin
      step();
      chk($sformatf("clear_ready_a_e%0d", e), 32'(rdy[0]), 32'(e >= 32));
      chk($sformatf("clear_ready_b_e%0d", e), 32'(rdy[1]), 32'(e >= 20));
    end
    ra = {5'd15, 5'd14, 5'd11, 5'd10};
    #1;
    for (int r = 0; r < 4; r++) chk($sformatf("clear_a_entry_p%0d", r), dout[0][r], 32'h0);
    for (int i = 0; i < 8; i++) begin
      ra = {5'(4*i+3), 5'(4*i+2), 5'(4*i+1), 5'(4*i)};
      step();
    end

    // Asynchronous reset ten edges into a sweep.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int e = 0; e < 10; e++) step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("midsweep_rst_ready_b", 32'(rdy[1]), 32'h0);
    chk("midsweep_rst_dout_b", dout[1][0], 32'h5A5A5A5A);
    chk("midsweep_rst_dout_c", dout[2][0], 32'h0000C1C1);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      chk($sformatf("rst_ready_a_e%0d", e), 32'(rdy[0]), 32'(e >= 32));
      chk($sformatf("rst_ready_b_e%0d", e), 32'(rdy[1]), 32'(e >= 20));
    end

    // Randomized traffic with conflicts, out-of-range addresses and occasional clears.
    for (int c = 0; c < 1500; c++) begin
      we = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        wa[p]  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        din[p] = $urandom;
      end
      for (int r = 0; r < 4; r++) begin
        ra[r] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      end
      clear = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
